mem_data: RTL and testbench
===========================

// Module: mem_data
// PURPOSE
//  - Word-addressed, single-port data memory for the RV32I core's load/store path.
//  - Synchronous write and registered (1-cycle) read, so it maps onto FPGA block RAM.
//  - Sits behind the load/store unit; the LSU supplies word addresses and handles byte lanes.
// PARAMETERS
//  - ADDR_WIDTH  13  word-address width; depth = 2**ADDR_WIDTH words (8192 by default)
//  - DATA_WIDTH  32  word width in bits
// PORTS
//  - clk     in   1           single clock; all state updates on its rising edge
//  - rst_n   in   1           reset, asynchronous and active-low
//  - we      in   1           write enable, sampled at posedge clk
//  - addr    in   ADDR_WIDTH  word address for both read and write
//  - dataIn  in   DATA_WIDTH  write data
//  - dout    out  DATA_WIDTH  registered read data
// BEHAVIOUR
//  - Storage: 2**ADDR_WIDTH x DATA_WIDTH array. Every address is valid; there is no out-of-range case.
//  - Reset (rst_n=0): dout clears to 0 immediately, without waiting for a clock edge.
//    - Writes are suppressed while rst_n=0.
//    - Array contents are NOT cleared by reset and survive reset assertion.
//    - Reset asserted mid-write: the write at that edge is dropped.
//  - Write: at posedge clk with rst_n=1 and we=1, mem[addr] <= dataIn.
//  - Read: at every posedge clk with rst_n=1, dout <= mem[addr], whether we is 0 or 1.
//    - Read latency is exactly 1 cycle.
//    - dout holds its value between edges and changes only at a posedge or on reset.
//  - Read-during-write to the same address (macro off): read-first.
//    - dout gets the OLD contents of mem[addr].
//    - The new data is visible on the read at the next edge.
//  - Back-to-back writes to different addresses on consecutive cycles must all commit, with no stall.
//  - Initial array contents after power-up are undefined. Verification must not rely on them.
//  - Expected implementation size: 120-400 lines, including the optional-feature logic and assertions.
// CONFIGURATION
//  - Macro MEM_DATA_WRITE_FIRST_EN.
//  - When defined: write-first behaviour.
//    - On a posedge with we=1, dout <= dataIn, i.e. the new data is forwarded to the output.
//    - This holds for any write, since read and write always share the same addr.
//  - When undefined: read-first, as described under BEHAVIOUR.
//  - All other behaviour is identical in both configurations.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles -> dout==0. A we=1 write during reset must not alter the array.
//  - Sequential writes: 0x12345678@0, 0x87654321@1, 0x01010101@2 on three consecutive edges with we=1.
//    Then we=0 and read addrs 0, 1, 2 -> dout equals each value one cycle after its address is applied.
//  - Read-during-write: mem[2]=0x01010101; apply we=1, addr=2, dataIn=0xFFFFFFFF for one edge.
//    -> dout==0x01010101 (macro off) or 0xFFFFFFFF (macro on).
//    Next edge with we=0 -> dout==0xFFFFFFFF.
//  - Overwrite: consecutive writes 0xFFFFFFFF then 0xDDDDDDDD to addr 2, then we=0, read addr 2 -> 0xDDDDDDDD.
//  - Reset retention: write 0xCAFEF00D@0x1FFF, then pulse rst_n low between edges -> dout==0 at once.
//    Read addr 0x1FFF after release -> 0xCAFEF00D.
//  - Hold: we=0 with addr stable for 3 cycles -> dout stays constant.

Source files
------------

// File: rtl/mem_data.sv
// Word-addressed single-port data memory: synchronous write, registered 1-cycle read.
// Optional macro MEM_DATA_WRITE_FIRST_EN selects write-first instead of read-first.
module mem_data #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] read_data;

    // The array has no reset so it maps onto block RAM; writes are gated by rst_n instead.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem[addr] <= dataIn;
        end
    end

`ifdef MEM_DATA_WRITE_FIRST_EN
    assign read_data = we ? dataIn : mem[addr];
`else
    assign read_data = mem[addr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= read_data;
        end
    end

endmodule

// File: tb/tb_mem_data.sv
// Directed self-checking bench for mem_data; honours MEM_DATA_WRITE_FIRST_EN.
module tb_mem_data;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [12:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dout;

    int total;
    int bad;

    mem_data dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .addr   (addr),
        .dataIn (dataIn),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic step(input logic w, input logic [12:0] a, input logic [31:0] d);
        we     = w;
        addr   = a;
        dataIn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 13'd5, 32'hBAD0BAD0);
        step(1'b1, 13'd5, 32'hBAD0BAD0);
        total++;
        if (dout !== 32'h0) begin
            bad++;
            $display("FAIL reset_dout actual=%h required=%h", dout, 32'h0);
        end
        rst_n = 1'b1;
        step(1'b1, 13'd5, 32'hAAAA5555);
        rst_n = 1'b0;
        step(1'b1, 13'd5, 32'h0BADF00D);
        step(1'b1, 13'd5, 32'h0BADF00D);
        rst_n = 1'b1;
        step(1'b0, 13'd5, 32'h0);
        total++;
        if (dout !== 32'hAAAA5555) begin
            bad++;
            $display("FAIL reset_write_blocked actual=%h required=%h", dout, 32'hAAAA5555);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] vals [3];
        vals[0] = 32'h12345678;
        vals[1] = 32'h87654321;
        vals[2] = 32'h01010101;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 13'(i), vals[i]);
`ifdef MEM_DATA_WRITE_FIRST_EN
            total++;
            if (dout !== vals[i]) begin
                bad++;
                $display("FAIL seq_forward[%0d] actual=%h required=%h", i, dout, vals[i]);
            end
`endif
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 13'(i), 32'h0);
            total++;
            if (dout !== vals[i]) begin
                bad++;
                $display("FAIL seq_read[%0d] actual=%h required=%h", i, dout, vals[i]);
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] exp_rdw;
`ifdef MEM_DATA_WRITE_FIRST_EN
        exp_rdw = 32'hFFFFFFFF;
`else
        exp_rdw = 32'h01010101;
`endif
        step(1'b1, 13'd2, 32'hFFFFFFFF);
        total++;
        if (dout !== exp_rdw) begin
            bad++;
            $display("FAIL rdw_same_edge actual=%h required=%h", dout, exp_rdw);
        end
        step(1'b0, 13'd2, 32'h0);
        total++;
        if (dout !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL rdw_next_edge actual=%h required=%h", dout, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_overwrite();
        logic [31:0] exp_second;
`ifdef MEM_DATA_WRITE_FIRST_EN
        exp_second = 32'hDDDDDDDD;
`else
        exp_second = 32'hFFFFFFFF;
`endif
        step(1'b1, 13'd2, 32'hFFFFFFFF);
        step(1'b1, 13'd2, 32'hDDDDDDDD);
        total++;
        if (dout !== exp_second) begin
            bad++;
            $display("FAIL overwrite_second_edge actual=%h required=%h", dout, exp_second);
        end
        step(1'b0, 13'd2, 32'h0);
        total++;
        if (dout !== 32'hDDDDDDDD) begin
            bad++;
            $display("FAIL overwrite_read actual=%h required=%h", dout, 32'hDDDDDDDD);
        end
    endtask

    task automatic test_reset_retention();
        step(1'b1, 13'h1FFF, 32'hCAFEF00D);
        step(1'b0, 13'h1FFF, 32'h0);
        total++;
        if (dout !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL retention_pre actual=%h required=%h", dout, 32'hCAFEF00D);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (dout !== 32'h0) begin
            bad++;
            $display("FAIL retention_async_clear actual=%h required=%h", dout, 32'h0);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (dout !== 32'h0) begin
            bad++;
            $display("FAIL retention_after_release actual=%h required=%h", dout, 32'h0);
        end
        step(1'b0, 13'h1FFF, 32'h0);
        total++;
        if (dout !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL retention_read actual=%h required=%h", dout, 32'hCAFEF00D);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 13'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 13'd1, 32'h0);
            total++;
            if (dout !== 32'h87654321) begin
                bad++;
                $display("FAIL hold[%0d] actual=%h required=%h", i, dout, 32'h87654321);
            end
        end
        addr = 13'd0;
        #3;
        total++;
        if (dout !== 32'h87654321) begin
            bad++;
            $display("FAIL hold_between_edges actual=%h required=%h", dout, 32'h87654321);
        end
        @(posedge clk);
        #1;
        total++;
        if (dout !== 32'h12345678) begin
            bad++;
            $display("FAIL hold_addr_change actual=%h required=%h", dout, 32'h12345678);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h00000000;
        vals[1] = 32'hFFFF0000;
        vals[2] = 32'h5A5AA5A5;
        vals[3] = 32'h13579BDF;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 13'h100 + 13'(i), vals[i]);
        end
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 13'h100 + 13'(i), 32'h0);
            total++;
            if (dout !== vals[i]) begin
                bad++;
                $display("FAIL b2b_read[%0d] actual=%h required=%h", i, dout, vals[i]);
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        addr   = '0;
        dataIn = '0;
        #1;
        test_reset();
        test_sequential();
        test_read_during_write();
        test_overwrite();
        test_reset_retention();
        test_hold();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
